// File: rtl/uart_pkg.sv
// Shared UART baud constants and divisor helper.
// Widths and reset defaults for the tick generator.
package uart_pkg;

  localparam int UART_DVSR_W       = 16;
  localparam int UART_FRAC_W       = 4;
  localparam int UART_OVS          = 16;
  localparam int UART_DEFAULT_INT  = 162;
  localparam int UART_DEFAULT_FRAC = 12;

  typedef struct packed {
    logic [UART_DVSR_W-1:0] int_part;
    logic [UART_FRAC_W-1:0] frac_part;
  } dvsr_t;

  // Rounded clk_hz / (baud * ovs) in fixed point.
  // 50 MHz, 19200 baud, x16 gives 162 + 12/16.
  function automatic dvsr_t calc_dvsr(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned ovs
  );
    longint unsigned den;
    longint unsigned fx;
    dvsr_t           d;
    den         = baud * ovs;
    fx          = ((clk_hz << UART_FRAC_W) + den / 2) / den;
    d.int_part  = UART_DVSR_W'(fx >> UART_FRAC_W);
    d.frac_part = UART_FRAC_W'(fx);
    return d;
  endfunction

endpackage

// File: rtl/frac_baud_gen_if.sv
// Host-side control and tick bundle for the
// fractional baud generator.
interface frac_baud_gen_if
  import uart_pkg::*;
#(
  parameter int DVSR_W = UART_DVSR_W,
  parameter int FRAC_W = UART_FRAC_W
);

  logic              en;
  logic              restart;
  logic              cfg_load;
  logic [DVSR_W-1:0] cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              s_tick;
  logic              bit_tick;
  logic              cfg_pending;
  logic [DVSR_W-1:0] q;

  modport master (
    output en, restart, cfg_load,
    output cfg_int, cfg_frac,
    input  s_tick, bit_tick,
    input  cfg_pending, q
  );

  modport slave (
    input  en, restart, cfg_load,
    input  cfg_int, cfg_frac,
    output s_tick, bit_tick,
    output cfg_pending, q
  );

endinterface

// File: rtl/frac_divider.sv
// Integer+fractional clock divider producing s_tick.
// Config goes through a shadow applied on a tick edge.
module frac_divider
  import uart_pkg::*;
#(
  parameter int DVSR_W       = UART_DVSR_W,
  parameter int FRAC_W       = UART_FRAC_W,
  parameter int DEFAULT_INT  = UART_DEFAULT_INT,
  parameter int DEFAULT_FRAC = UART_DEFAULT_FRAC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic              cfg_load,
  input  logic [DVSR_W-1:0] cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              s_tick,
  output logic              cfg_pending,
  output logic [DVSR_W-1:0] q
);

  logic [DVSR_W-1:0] int_reg;
  logic [DVSR_W-1:0] shd_int;
  logic [DVSR_W-1:0] int_cl;
  logic [DVSR_W-1:0] cnt;
  logic [DVSR_W-1:0] last;
  logic [FRAC_W-1:0] frac_reg;
  logic [FRAC_W-1:0] shd_frac;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;
  logic              ext;
  logic              pend;
  logic              tick;
  logic              now;

  // int >= 2 keeps an idle cycle between ticks
  assign int_cl = (cfg_int < DVSR_W'(2)) ?
                  DVSR_W'(2) : cfg_int;

  // ext stretches this period by one cycle
  assign last = int_reg - DVSR_W'(1) + DVSR_W'(ext);
  assign tick = en & ~restart & (cnt == last);
  assign sum  = {1'b0, acc} + {1'b0, frac_reg};

  // stopped or restarting: nothing to finish
  assign now  = ~en | restart;

  // period counter and fractional accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      ext <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      acc <= '0;
      ext <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      acc <= sum[FRAC_W-1:0];
      ext <= sum[FRAC_W];
    end else if (en) begin
      cnt <= cnt + DVSR_W'(1);
    end
  end

  // divisor config: immediate when idle, else at tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_reg  <= DVSR_W'(DEFAULT_INT);
      frac_reg <= FRAC_W'(DEFAULT_FRAC);
      shd_int  <= DVSR_W'(DEFAULT_INT);
      shd_frac <= FRAC_W'(DEFAULT_FRAC);
      pend     <= 1'b0;
    end else if (cfg_load && now) begin
      int_reg  <= int_cl;
      frac_reg <= cfg_frac;
      pend     <= 1'b0;
    end else if (cfg_load) begin
      shd_int  <= int_cl;
      shd_frac <= cfg_frac;
      pend     <= 1'b1;
    end else if (tick && pend) begin
      int_reg  <= shd_int;
      frac_reg <= shd_frac;
      pend     <= 1'b0;
    end
  end

  assign s_tick      = tick;
  assign cfg_pending = pend;
  assign q           = cnt;

endmodule

// File: rtl/frac_baud_gen.sv
// Runtime-programmable UART baud tick generator:
// oversample tick plus bit tick every OVS ticks.
module frac_baud_gen
  import uart_pkg::*;
#(
  parameter int DVSR_W       = UART_DVSR_W,
  parameter int FRAC_W       = UART_FRAC_W,
  parameter int OVS          = UART_OVS,
  parameter int DEFAULT_INT  = UART_DEFAULT_INT,
  parameter int DEFAULT_FRAC = UART_DEFAULT_FRAC
) (
  input logic           clk,
  input logic           reset,
  frac_baud_gen_if.slave bus
);

  localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;

  logic [OW-1:0] ovs_cnt;
  logic          s_tick;
  logic          ovs_last;

  frac_divider #(
    .DVSR_W       (DVSR_W),
    .FRAC_W       (FRAC_W),
    .DEFAULT_INT  (DEFAULT_INT),
    .DEFAULT_FRAC (DEFAULT_FRAC)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .en          (bus.en),
    .restart     (bus.restart),
    .cfg_load    (bus.cfg_load),
    .cfg_int     (bus.cfg_int),
    .cfg_frac    (bus.cfg_frac),
    .s_tick      (s_tick),
    .cfg_pending (bus.cfg_pending),
    .q           (bus.q)
  );

  assign ovs_last = (ovs_cnt == OW'(OVS - 1));

  // oversample counter, wraps OVS-1 -> 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovs_cnt <= '0;
    end else if (bus.restart) begin
      ovs_cnt <= '0;
    end else if (s_tick) begin
      ovs_cnt <= ovs_last ? '0 : ovs_cnt + OW'(1);
    end
  end

  assign bus.s_tick   = s_tick;
  assign bus.bit_tick = s_tick & ovs_last;

endmodule

// File: tb/tb_frac_baud_gen.sv
// Scoreboard bench for frac_baud_gen: expected tick
// cycles are queued, a monitor pops on each s_tick.
module tb_frac_baud_gen;

  localparam int DW   = 16;
  localparam int FW   = 4;
  localparam int NOVS = 16;

  typedef struct {
    int c;
    bit b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc;
  int   errors = 0;
  int   checks = 0;
  int   ovs_m = 0;
  exp_t exp_q[$];
  int   tick_log[$];

  frac_baud_gen_if #(.DVSR_W(DW), .FRAC_W(FW)) bus ();

  frac_baud_gen #(
    .DVSR_W       (DW),
    .FRAC_W       (FW),
    .OVS          (NOVS),
    .DEFAULT_INT  (162),
    .DEFAULT_FRAC (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // cycle index; 0 is the first cycle after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic push(input int c);
    exp_q.push_back('{c, (ovs_m == NOVS - 1)});
    ovs_m = (ovs_m == NOVS - 1) ? 0 : ovs_m + 1;
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int ci, input int cf);
    bus.cfg_load = 1'b1;
    bus.cfg_int  = DW'(ci);
    bus.cfg_frac = FW'(cf);
  endtask

  // restart with immediate config; returns in cnt=0 cycle
  task automatic reload(input int ci, input int cf);
    bus.en      = 1'b0;
    bus.restart = 1'b1;
    load(ci, cf);
    @(posedge clk);
    #1;
    bus.restart  = 1'b0;
    bus.cfg_load = 1'b0;
    ovs_m        = 0;
  endtask

  // monitor: compare each s_tick with the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.s_tick) begin
          tick_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick: got cycle %0d expected none",
                     cyc);
          end else begin
            e = exp_q.pop_front();
            chk("tick_cycle", cyc, e.c);
            chk("bit_tick", bus.bit_tick, e.b);
          end
        end else begin
          chk("bit_tick_idle", bus.bit_tick, 0);
        end
      end
    end
  end

  // stimulus
  initial begin
    int s;
    int t;
    bus.en       = 1'b0;
    bus.restart  = 1'b0;
    bus.cfg_load = 1'b0;
    bus.cfg_int  = '0;
    bus.cfg_frac = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", bus.q, 0);
    chk("rst_s_tick", bus.s_tick, 0);
    chk("rst_bit_tick", bus.bit_tick, 0);
    chk("rst_pending", bus.cfg_pending, 0);

    // int=4 loaded while stopped, then run 16 ticks
    load(4, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("pend_idle_load", bus.cfg_pending, 0);
    bus.cfg_load = 1'b0;
    bus.en       = 1'b1;
    s = cyc;
    for (int k = 0; k < 16; k++) push(s + 3 + 4 * k);
    go(s + 1);
    chk("q_run", bus.q, 1);
    go(s + 64);
    bus.en = 1'b0;

    // fractional 4.5: intervals 4,4,5,4,5...
    reload(4, 8);
    bus.en = 1'b1;
    s = cyc;
    tick_log.delete();
    t = s + 3;
    push(t);
    for (int k = 2; k <= 101; k++) begin
      t += (k % 2 == 0) ? 4 : 5;
      push(t);
    end
    go(t + 1);
    bus.en = 1'b0;
    chk("frac_tick_count", tick_log.size(), 101);
    if (tick_log.size() >= 101)
      chk("frac_span_100", tick_log[100] - tick_log[0], 450);

    // deferred load, overwrite, load on a tick
    reload(10, 0);
    bus.en = 1'b1;
    s = cyc;
    push(s + 9);
    push(s + 19);
    push(s + 29);
    push(s + 35);
    push(s + 41);
    push(s + 45);
    go(s + 22);
    load(8, 0);
    go(s + 23);
    load(6, 0);
    go(s + 24);
    bus.cfg_load = 1'b0;
    chk("pend_set", bus.cfg_pending, 1);
    go(s + 29);
    chk("pend_at_tick", bus.cfg_pending, 1);
    go(s + 30);
    chk("pend_cleared", bus.cfg_pending, 0);
    go(s + 35);
    load(4, 0);
    go(s + 36);
    bus.cfg_load = 1'b0;
    chk("pend_tick_load", bus.cfg_pending, 1);
    go(s + 46);
    bus.en = 1'b0;

    // en gating: freeze at cnt=2 for 7 cycles
    reload(5, 0);
    bus.en = 1'b1;
    s = cyc;
    push(s + 11);
    push(s + 16);
    go(s + 2);
    chk("q_before_hold", bus.q, 2);
    bus.en = 1'b0;
    go(s + 4);
    chk("q_hold_a", bus.q, 2);
    go(s + 8);
    chk("q_hold_b", bus.q, 2);
    go(s + 9);
    bus.en = 1'b1;
    go(s + 17);
    bus.en = 1'b0;

    // restart with ovs_cnt=9, on a would-be tick
    reload(3, 0);
    bus.en = 1'b1;
    s = cyc;
    for (int k = 0; k < 9; k++) push(s + 2 + 3 * k);
    ovs_m = 0;
    for (int k = 0; k < 16; k++) push(s + 32 + 3 * k);
    go(s + 29);
    bus.restart = 1'b1;
    go(s + 30);
    bus.restart = 1'b0;
    chk("q_restart", bus.q, 0);
    go(s + 78);
    bus.en = 1'b0;

    // clamp: int=0 then int=1 both give period 2
    reload(0, 0);
    bus.en = 1'b1;
    s = cyc;
    for (int k = 0; k < 4; k++) push(s + 1 + 2 * k);
    push(s + 11);
    push(s + 13);
    push(s + 15);
    go(s + 8);
    bus.en = 1'b0;
    go(s + 9);
    load(1, 0);
    go(s + 10);
    bus.cfg_load = 1'b0;
    chk("pend_clamp", bus.cfg_pending, 0);
    bus.en = 1'b1;
    go(s + 16);
    bus.en = 1'b0;

    // reset while pending restores defaults
    reload(10, 0);
    bus.en = 1'b1;
    s = cyc;
    go(s + 3);
    load(7, 0);
    go(s + 4);
    bus.cfg_load = 1'b0;
    chk("pend_pre_rst", bus.cfg_pending, 1);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst2_pending", bus.cfg_pending, 0);
    chk("rst2_q", bus.q, 0);
    chk("rst2_s_tick", bus.s_tick, 0);
    ovs_m = 0;
    push(161);
    push(323);
    push(486);
    reset = 1'b0;
    go(487);
    bus.en = 1'b0;
    go(490);

    chk("missing_ticks", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
